// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the in-place FFT datapath writeback stage.
//   - shamt_bits_for(): maps a data word width to the shift-amount width that
//     the butterfly PE produces for it (8 -> 4, 16 -> 5, anything else -> 0).
//   - cplx_t / addr_pair_t: complex sample and write-address pair for the
//     default configuration (width=8, addrbits=9).
//   - wb_state_t: writeback stage FSM states.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_ADDRBITS = 9;

    // Returns 0 for an unsupported width so the caller's check fails.
    function automatic int shamt_bits_for(input int w);
        return (w == 8) ? 4 : ((w == 16) ? 5 : 0);
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0] re;
        logic [DEF_WIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [DEF_ADDRBITS-1:0] addr0;
        logic [DEF_ADDRBITS-1:0] addr1;
    } addr_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/fft_writeback_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write request and data; ignored when full unless a pop
//                   happens in the same cycle
//   pop_i, rdata_o  read request and head entry; pop ignored when empty
//   full_o, empty_o occupancy flags
// depth must be a power of two (pointers wrap naturally) and at least 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int dw    = 18,
    parameter int depth = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [dw-1:0] wdata_i,
    output logic [dw-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(depth);

    logic [dw-1:0] r_mem [depth];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == FULL_COUNT);
    assign w_do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fft_writeback.sv
// -----------------------------------------------------------------------------
// fft_writeback
// Writeback stage after the butterfly PE of the in-place FFT. Each PE result
// beat is paired with the write-address pair queued by the read sequencer when
// its operands were fetched, both results are written back to memory, and the
// minimum shamt over the stage is reported as the next stage's block shift.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_valid_i/_ready_o    PE result handshake
//   y0r_i..y1i_i, shamt_i      PE results and shift amount of the beat
//   addr_valid_i, addr0_i/1_i  address pair push from the read sequencer
//   addr_full_o                address FIFO full
//   stage_start_i, pairs_i     stage start pulse and butterfly count
//   mem_we_o, mem_addr*_o,     write port (both addresses written together),
//   mem_wdata*_o, mem_ready_i  data {real, imag}; held until mem_ready_i
//   stage_done_o               one-cycle stage completion pulse
//   next_shamt_o               minimum shamt of the last completed stage
//   err_o                      sticky protocol error
// -----------------------------------------------------------------------------
module fft_writeback
    import fft_pkg::*;
#(
    parameter int width      = 8,
    parameter int shamtbits  = 4,
    parameter int addrbits   = 9,
    parameter int fifo_depth = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_axis_valid_i,
    output logic                 s_axis_ready_o,
    input  logic [width-1:0]     y0r_i,
    input  logic [width-1:0]     y0i_i,
    input  logic [width-1:0]     y1r_i,
    input  logic [width-1:0]     y1i_i,
    input  logic [shamtbits-1:0] shamt_i,
    input  logic                 addr_valid_i,
    input  logic [addrbits-1:0]  addr0_i,
    input  logic [addrbits-1:0]  addr1_i,
    output logic                 addr_full_o,
    input  logic                 stage_start_i,
    input  logic [addrbits-1:0]  pairs_i,
    output logic                 mem_we_o,
    output logic [addrbits-1:0]  mem_addr0_o,
    output logic [addrbits-1:0]  mem_addr1_o,
    output logic [2*width-1:0]   mem_wdata0_o,
    output logic [2*width-1:0]   mem_wdata1_o,
    input  logic                 mem_ready_i,
    output logic                 stage_done_o,
    output logic [shamtbits-1:0] next_shamt_o,
    output logic                 err_o
);

    generate
        if (shamtbits != shamt_bits_for(width)) begin : g_bad_shamtbits
            $error("fft_writeback: width must be 8 (shamtbits 4) or 16 (shamtbits 5)");
        end
        if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
            $error("fft_writeback: fifo_depth must be a power of two, at least 2");
        end
    endgenerate

    typedef struct packed {
        logic [addrbits-1:0] addr0;
        logic [addrbits-1:0] addr1;
    } wb_pair_t;

    localparam int SW = $clog2(fifo_depth) + 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(fifo_depth);

    wb_state_t             r_state;
    wb_state_t             w_state_next;

    logic                  r_we;
    logic [addrbits-1:0]   r_addr0;
    logic [addrbits-1:0]   r_addr1;
    logic [2*width-1:0]    r_wdata0;
    logic [2*width-1:0]    r_wdata1;
    logic [addrbits-1:0]   r_cnt;
    logic [addrbits-1:0]   r_pairs;
    logic [shamtbits-1:0]  r_min;
    logic [shamtbits-1:0]  r_next_shamt;
    logic [SW-1:0]         r_starve;
    logic                  r_err;

    wb_pair_t              w_push_pair;
    wb_pair_t              w_head_pair;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_write_done;
    logic                  w_last_beat;
    logic                  w_starving;
    logic                  w_start_now;
    logic                  w_err_set;

    assign w_push_pair = '{addr0: addr0_i, addr1: addr1_i};

    sync_fifo #(
        .dw    ($bits(wb_pair_t)),
        .depth (fifo_depth)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (addr_valid_i),
        .pop_i   (w_accept),
        .wdata_i (w_push_pair),
        .rdata_o (w_head_pair),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_accept     = s_axis_valid_i && w_ready;
    assign w_write_done = r_we && mem_ready_i;
    assign w_last_beat  = w_accept && (r_cnt == (r_pairs - 1'b1));
    assign w_start_now  = (r_state == IDLE) && stage_start_i;
    // The PE keeps running; a beat with no address to pair with is only an
    // error once it has waited longer than the FIFO could ever lag.
    assign w_starving   = (r_state == RUN) && s_axis_valid_i && w_fifo_empty;

    assign w_err_set = (addr_valid_i && w_fifo_full && !w_accept)
                     || (stage_start_i && (r_state != IDLE))
                     || (w_starving && (r_starve == STARVE_MAX))
                     || ((r_state == DONE) && !w_fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        stage_done_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (stage_start_i) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_ready = !w_fifo_empty && (!r_we || mem_ready_i);
                if (w_last_beat) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_we || w_write_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                stage_done_o = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_addr0      <= '0;
            r_addr1      <= '0;
            r_wdata0     <= '0;
            r_wdata1     <= '0;
            r_cnt        <= '0;
            r_pairs      <= '0;
            r_min        <= '0;
            r_next_shamt <= '0;
            r_starve     <= '0;
            r_err        <= 1'b0;
        end else begin
            // Output register: a new beat may replace a write completing in
            // the same cycle; otherwise the write holds until accepted.
            if (w_accept) begin
                r_we     <= 1'b1;
                r_addr0  <= w_head_pair.addr0;
                r_addr1  <= w_head_pair.addr1;
                r_wdata0 <= {y0r_i, y0i_i};
                r_wdata1 <= {y1r_i, y1i_i};
            end else if (mem_ready_i) begin
                r_we <= 1'b0;
            end

            if (w_start_now) begin
                r_pairs <= (pairs_i == '0) ? addrbits'(1) : pairs_i;
                r_cnt   <= '0;
                r_min   <= '1;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (shamt_i < r_min) begin
                    r_min <= shamt_i;
                end
            end

            if (r_state == DONE) begin
                r_next_shamt <= r_min;
            end

            if (w_starving) begin
                if (r_starve != STARVE_MAX) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_starve <= '0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_axis_ready_o = w_ready;
    assign addr_full_o    = w_fifo_full;
    assign mem_we_o       = r_we;
    assign mem_addr0_o    = r_addr0;
    assign mem_addr1_o    = r_addr1;
    assign mem_wdata0_o   = r_wdata0;
    assign mem_wdata1_o   = r_wdata1;
    assign next_shamt_o   = r_next_shamt;
    assign err_o          = r_err;

endmodule

// File: doc/fft_writeback.md
Name: fft_writeback

Overview:
- Stage directly downstream of the butterfly processing element in the in-place FFT datapath.
- Pairs each PE result beat with the write addresses issued when its operands were read, using an internal address FIFO to absorb PE pipeline latency.
- Writes both complex results back to the in-place memory and tracks the minimum shamt over a stage, which is the block-floating-point shift for the next stage.
- Signals stage completion to the FFT sequencer.

Parameters:
- width, 8: data word width per real/imag part; 8 or 16 only.
- shamtbits, 4: shift-amount width; 4 with width=8, 5 with width=16. Any other combination fails at elaboration.
- addrbits, 9: memory address width.
- fifo_depth, 16: address FIFO entries; power of two, at least PE pipeline depth + 2.

Ports:
- clk_rstn_i  slave(clk_rstn_intrf)  -  single clock; asynchronous, active-low reset.
- s_axis  s_axis(axi_ctr_intrf)  -  valid/ready handshake from PE m_axis.
- y0r_i, y0i_i, y1r_i, y1i_i  in  width each  -  PE results.
- shamt_i  in  shamtbits  -  PE shamt_o for this beat.
- addr_valid_i  in  1  -  read sequencer pushes an address pair.
- addr0_i, addr1_i  in  addrbits each  -  write addresses for the pair just launched.
- addr_full_o  out  1  -  FIFO full; sequencer must not push.
- stage_start_i  in  1  -  one-cycle pulse that begins a stage.
- pairs_i  in  addrbits  -  butterflies in this stage; sampled at stage_start_i.
- mem_we_o  out  1  -  write strobe, both ports.
- mem_addr0_o, mem_addr1_o  out  addrbits each  -  write addresses.
- mem_wdata0_o, mem_wdata1_o  out  2*width each  -  {real, imag}.
- mem_ready_i  in  1  -  memory accepts the write when high together with mem_we_o.
- stage_done_o  out  1  -  one-cycle pulse when the stage completes.
- next_shamt_o  out  shamtbits  -  minimum shamt of the last completed stage.
- err_o  out  1  -  sticky protocol error.

Behaviour:
- Reset values: all outputs 0, except next_shamt_o = 0; FIFO empty; FSM in IDLE.
- Reset asserted mid-operation: FIFO is flushed, counters cleared, in-flight write discarded.
- FIFO push: addr_valid_i && !addr_full_o. A push while full is dropped and sets err_o. Push and pop in the same cycle are legal, including when full (pop frees the slot first).
- s_axis ready is high iff state==RUN && FIFO non-empty && (output register empty || mem_ready_i).
- Beat acceptance: valid && ready pops one FIFO entry and loads the output register. The following cycle drives mem_we_o=1 with the data, addresses, {y0r,y0i} and {y1r,y1i}. Latency from beat to mem_we_o is 1 cycle.
- mem_we_o and all write outputs hold stable until mem_ready_i=1. Back-to-back beats sustain one write per cycle while mem_ready_i stays high.
- The PE is never stalled by FIFO-empty alone. A beat presented while the FIFO is empty in RUN for more than fifo_depth cycles sets err_o.
- FSM IDLE: stage_start_i latches pairs_i (0 is treated as 1), clears cnt, sets min_shamt to all-ones, then goes to RUN.
- FSM RUN: on each accepted beat, cnt++ and min_shamt = min(min_shamt, shamt_i). After the beat where cnt reaches pairs-1, go to DRAIN; ready drops.
- FSM DRAIN: wait until the output register's write completes (mem_we_o && mem_ready_i), then go to DONE.
- FSM DONE: stage_done_o=1 for exactly one cycle; next_shamt_o <= min_shamt (held until the next DONE); return to IDLE.
- stage_start_i outside IDLE is ignored and sets err_o.
- Leftover FIFO entries at DONE set err_o. They are retained, not flushed.
- err_o clears only on reset.

Decomposition:
- Shared package fft_pkg:
  - localparam rule mapping width to shamtbits.
  - typedef cplx_t {logic [width-1:0] re, im}.
  - typedef addr_pair_t {addr0, addr1}.
  - wb_state_t enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module: sync_fifo (parameterised width/depth, full/empty flags, simultaneous push/pop), instantiated for addr_pair_t.

Test Plan:
- Basic stage: pairs_i=4; push addrs (0,1),(2,3),(4,5),(6,7); PE beats with shamt 3,1,2,3; mem_ready_i=1 → four writes at cycles beat+1 carrying the matching addresses/data; stage_done_o pulse one cycle after the last write; next_shamt_o=1.
- Backpressure: mem_ready_i low for 5 cycles mid-stream → mem_we_o/address/data held constant, s_axis ready low, no beat lost; write count still 4.
- FIFO limits: push 16 with no beats → addr_full_o=1; a 17th push sets err_o. Simultaneous push+pop when full → entry accepted, no error.
- Order/latency: 8-deep PE latency emulated, random valid gaps → written data always paired with its own address pair (scoreboard check).
- Protocol errors: stage_start_i during RUN → ignored, err_o=1. pairs_i=0 → behaves as 1 pair.
- Reset mid-stage after 2 of 4 beats → outputs 0, FIFO empty, next stage_start runs cleanly.
